// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 32;

  localparam int RQ_CPU = 0;
  localparam int RQ_AUX = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner select for two requesters: round-robin by default,
// fixed priority (requester 0 first) when MEM_ARB_FIXED_PRIO_EN is defined.
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] winner,
  output logic       valid
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    winner = 2'b00;
    valid  = |req;
    if (req[RQ_CPU]) begin
      winner[RQ_CPU] = 1'b1;
    end else if (req[RQ_AUX]) begin
      winner[RQ_AUX] = 1'b1;
    end
  end
`else
  always_comb begin
    winner = 2'b00;
    valid  = |req;
    // On a tie the requester that did not go last wins.
    if (req == 2'b11) begin
      winner = last_owner ? 2'b01 : 2'b10;
    end else begin
      winner = req;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sequencing single-word accesses to the shared memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_enable,
  input  logic              rq0_req,
  input  logic              rq0_we,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_gnt,
  output logic              rq0_done,
  output logic [DATA_W-1:0] rq0_rdata,
  input  logic              rq1_req,
  input  logic              rq1_we,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_gnt,
  output logic              rq1_done,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  arb_state_e        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              txn_we_q, txn_we_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0]        pick_winner;
  logic              pick_valid;
  logic              win_aux;

  arb_rr_pick u_pick (
    .req        ({rq1_req, rq0_req}),
    .last_owner (last_owner_q),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign win_aux = pick_winner[RQ_AUX];

  // last_owner also names the requester whose transaction is in flight.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    txn_we_d     = txn_we_q;
    mem_we_d     = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    gnt_d        = 2'b00;
    done_d       = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      ACCESS: state_d = RESP;
      RESP: begin
        done_d[last_owner_q] = 1'b1;
        if (!txn_we_q) begin
          if (last_owner_q) begin
            rdata1_d = mem_read_data;
          end else begin
            rdata0_d = mem_read_data;
          end
        end
      end
      default: ;
    endcase

    if (state_q != ACCESS) begin
      if (pick_valid) begin
        state_d      = ACCESS;
        gnt_d        = pick_winner;
        last_owner_d = win_aux;
        txn_we_d     = win_aux ? rq1_we : rq0_we;
        mem_we_d     = win_aux ? rq1_we : rq0_we;
        addr_d       = win_aux ? rq1_addr : rq0_addr;
        wdata_d      = win_aux ? rq1_wdata : rq0_wdata;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      txn_we_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else if (clk_enable) begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      txn_we_q     <= txn_we_d;
      mem_we_q     <= mem_we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign rq0_gnt           = gnt_q[RQ_CPU];
  assign rq1_gnt           = gnt_q[RQ_AUX];
  assign rq0_done          = done_q[RQ_CPU];
  assign rq1_done          = done_q[RQ_AUX];
  assign rq0_rdata         = rdata0_q;
  assign rq1_rdata         = rdata1_q;
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;
  assign mem_write_enable  = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected read
// data per requester; a monitor pops and compares on every done pulse.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_enable = 1'b0;
  logic          rq0_req = 1'b0, rq0_we = 1'b0;
  logic [AW-1:0] rq0_addr = '0;
  logic [DW-1:0] rq0_wdata = '0;
  logic          rq1_req = 1'b0, rq1_we = 1'b0;
  logic [AW-1:0] rq1_addr = '0;
  logic [DW-1:0] rq1_wdata = '0;
  logic          rq0_gnt, rq0_done, rq1_gnt, rq1_done;
  logic [DW-1:0] rq0_rdata, rq1_rdata;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_enable;
  logic [DW-1:0] mem_read_data;

  logic [DW-1:0] mem [0:255];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_div = 1;
  int we_cnt = 0;
  int gnt_cnt1 = 0;
  logic pd0 = 1'b0, pd1 = 1'b0, pg1 = 1'b0;
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clk_enable        (clk_enable),
    .rq0_req           (rq0_req),
    .rq0_we            (rq0_we),
    .rq0_addr          (rq0_addr),
    .rq0_wdata         (rq0_wdata),
    .rq0_gnt           (rq0_gnt),
    .rq0_done          (rq0_done),
    .rq0_rdata         (rq0_rdata),
    .rq1_req           (rq1_req),
    .rq1_we            (rq1_we),
    .rq1_addr          (rq1_addr),
    .rq1_wdata         (rq1_wdata),
    .rq1_gnt           (rq1_gnt),
    .rq1_done          (rq1_done),
    .rq1_rdata         (rq1_rdata),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_enable  (mem_write_enable),
    .mem_read_data     (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: registered read, write commits on a tick.
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (clk_enable) begin
      if (mem_write_enable) mem[mem_write_address] <= mem_write_data;
      mem_read_data <= mem[mem_read_address];
    end
  end

  always @(posedge clk) begin
    if (clk_enable && mem_write_enable) we_cnt <= we_cnt + 1;
  end

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt++;
      clk_enable = ((cnt % en_div) == 0);
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  // Monitor: compares rdata against the scoreboard at each done rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rq0_done && !pd0) begin
        if (exp_q0.size() == 0) checkOutput("rq0_unexpected_done", 1, 0);
        else checkOutput("rq0_rdata", rq0_rdata, exp_q0.pop_front());
      end
      if (rq1_done && !pd1) begin
        if (exp_q1.size() == 0) checkOutput("rq1_unexpected_done", 1, 0);
        else checkOutput("rq1_rdata", rq1_rdata, exp_q1.pop_front());
      end
      if (rq1_gnt && !pg1) gnt_cnt1++;
      pd0 = rq0_done;
      pd1 = rq1_done;
      pg1 = rq1_gnt;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic curGnt(input int rq);
    return (rq == 0) ? rq0_gnt : rq1_gnt;
  endfunction

  function automatic logic curDone(input int rq);
    return (rq == 0) ? rq0_done : rq1_done;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic waitTicks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!clk_enable);
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    rq0_req = 1'b0;
    rq1_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One transaction: push expectation, hold request until gnt, wait for done.
  task automatic applyStimulus(input int rq, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] exp,
                               output int gnt_width, output int lat);
    int n;
    int g_cyc;
    if (rq == 0) begin
      exp_q0.push_back(exp);
      rq0_we = we; rq0_addr = addr; rq0_wdata = wdata; rq0_req = 1'b1;
    end else begin
      exp_q1.push_back(exp);
      rq1_we = we; rq1_addr = addr; rq1_wdata = wdata; rq1_req = 1'b1;
    end
    n = 0;
    gnt_width = 0;
    do begin @(negedge clk); n++; end while (!curGnt(rq) && n < 200);
    checkOutput("gnt_seen", {31'd0, curGnt(rq)}, 1);
    g_cyc = cyc;
    if (rq == 0) rq0_req = 1'b0; else rq1_req = 1'b0;
    while (curGnt(rq) && n < 400) begin gnt_width++; @(negedge clk); n++; end
    while (!curDone(rq) && n < 600) begin @(negedge clk); n++; end
    checkOutput("done_seen", {31'd0, curDone(rq)}, 1);
    lat = cyc - g_cyc;
  endtask

  initial begin
    int w, l, we0, g1, n, k;
    int seq [6];
    int gc [6];

    $display("[TB] preload and reset");
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h05, 32'h0BADF00D);
    preload(8'h20, 32'h11111111);
    preload(8'h21, 32'h22222222);
    preload(8'h77, 32'hAAAA5555);

    checkOutput("rst_rq0_gnt", {31'd0, rq0_gnt}, 0);
    checkOutput("rst_rq1_gnt", {31'd0, rq1_gnt}, 0);
    checkOutput("rst_rq0_done", {31'd0, rq0_done}, 0);
    checkOutput("rst_rq1_done", {31'd0, rq1_done}, 0);
    checkOutput("rst_rq0_rdata", rq0_rdata, 0);
    checkOutput("rst_rq1_rdata", rq1_rdata, 0);
    checkOutput("rst_mem_raddr", {24'd0, mem_read_address}, 0);
    checkOutput("rst_mem_waddr", {24'd0, mem_write_address}, 0);
    checkOutput("rst_mem_wdata", mem_write_data, 0);
    checkOutput("rst_mem_we", {31'd0, mem_write_enable}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single read");
    g1 = gnt_cnt1; we0 = we_cnt;
    applyStimulus(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, w, l);
    checkOutput("rd_gnt_width", w, 1);
    checkOutput("rd_latency", l, 2);
    checkOutput("rd_rq1_rdata", rq1_rdata, 0);
    checkOutput("rd_rq1_gnts", gnt_cnt1 - g1, 0);
    checkOutput("rd_no_commit", we_cnt - we0, 0);

    $display("[TB] write then read");
    we0 = we_cnt;
    applyStimulus(1, 1'b1, 8'h05, 32'hCAFEF00D, 32'h0, w, l);
    checkOutput("wr_commit_ticks", we_cnt - we0, 1);
    checkOutput("wr_mem_word", mem[8'h05], 32'hCAFEF00D);
    checkOutput("wr_latency", l, 2);
    applyStimulus(1, 1'b0, 8'h05, 32'h0, 32'hCAFEF00D, w, l);
    checkOutput("rd_after_wr_latency", l, 2);

    $display("[TB] sparse enable");
    en_div = 4;
    applyStimulus(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, w, l);
    checkOutput("sparse_gnt_width", w, 4);
    checkOutput("sparse_latency", l, 8);
    en_div = 1;
    waitTicks(3);

    $display("[TB] contention");
    doReset();
    rq0_we = 1'b0; rq0_addr = 8'h20;
    rq1_we = 1'b0; rq1_addr = 8'h21;
    rq0_req = 1'b1; rq1_req = 1'b1;
    k = 0; n = 0;
    while (k < 6 && n < 100) begin
      @(negedge clk);
      n++;
      if (rq0_gnt || rq1_gnt) begin
        seq[k] = rq1_gnt ? 1 : 0;
        gc[k] = cyc;
        if (rq0_gnt) exp_q0.push_back(32'h11111111);
        if (rq1_gnt) exp_q1.push_back(32'h22222222);
        k++;
      end
    end
    rq0_req = 1'b0; rq1_req = 1'b0;
    checkOutput("cont_grant_count", k, 6);
    for (int i = 0; i < k; i++) begin
      checkOutput($sformatf("cont_owner%0d", i), seq[i], i % 2);
      if (i > 0) checkOutput($sformatf("cont_spacing%0d", i), gc[i] - gc[i-1], 2);
    end
    waitTicks(4);

    $display("[TB] reset during write");
    we0 = we_cnt;
    rq0_we = 1'b1; rq0_addr = 8'h77; rq0_wdata = 32'h12345678; rq0_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rq0_gnt && n < 50);
    checkOutput("rstw_gnt_seen", {31'd0, rq0_gnt}, 1);
    rst_n = 1'b0;
    rq0_req = 1'b0;
    #1;
    checkOutput("rstw_we_dropped", {31'd0, mem_write_enable}, 0);
    checkOutput("rstw_gnt_cleared", {31'd0, rq0_gnt}, 0);
    repeat (3) @(negedge clk);
    checkOutput("rstw_word_kept", mem[8'h77], 32'hAAAA5555);
    checkOutput("rstw_commits", we_cnt - we0, 0);
    rst_n = 1'b1;
    rq0_we = 1'b0; rq0_addr = 8'h20;
    rq1_we = 1'b0; rq1_addr = 8'h21;
    rq0_req = 1'b1; rq1_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(rq0_gnt || rq1_gnt) && n < 50);
    checkOutput("tie_rq0_gnt", {31'd0, rq0_gnt}, 1);
    checkOutput("tie_rq1_gnt", {31'd0, rq1_gnt}, 0);
    if (rq0_gnt) exp_q0.push_back(32'h11111111);
    if (rq1_gnt) exp_q1.push_back(32'h22222222);
    rq0_req = 1'b0; rq1_req = 1'b0;
    waitTicks(4);

    checkOutput("sb_left_rq0", exp_q0.size(), 0);
    checkOutput("sb_left_rq1", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
